alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
- Parametrised successor to the 1-bit ALU slice: a full WIDTH-bit registered ALU for the CPU datapath.
- Single-cycle ops: AND, OR, ADD, SUB, SLT, NOR.
- Adds an iterative unsigned shift-add multiply with a start/ready/valid handshake, plus registered zero/carry/overflow flags.
- Sits between the register file read stage and writeback; the control unit stalls on ready_o.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous active-low reset.
- start_i  input  1  issue request; accepted only when ready_o=1.
- ctrl_i  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MULU.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ready_o  output  1  block idle and able to accept start_i.
- valid_o  output  1  one-cycle pulse: result/flags updated.
- result_o  output  WIDTH  result (MULU: low half of product).
- hi_o  output  WIDTH  MULU high half of product; 0 for all other ops.
- zero_o  output  1  result_o==0 (MULU: full 2*WIDTH product ==0).
- cout_o  output  1  carry out (ADD, SUB) else 0.
- overflow_o  output  1  signed overflow (ADD, SUB) else 0.
- illegal_o  output  1  opcode not in list; registered with the valid pulse.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, ready_o=1, valid_o=0, and all result/flag outputs =0. A multiply in flight is aborted with no valid pulse.
- FSM states: IDLE, MUL, DONE.
- IDLE, start_i=1, non-MULU op:
  - Compute combinationally and register at the accepting edge.
  - valid_o=1 for exactly the following cycle.
  - Stay IDLE (latency 1, throughput 1/cycle).
- IDLE, start_i=1, ctrl_i=MULU:
  - Latch operands; clear the 2*WIDTH accumulator; counter=0.
  - Go to MUL; ready_o=0.
- MUL: each cycle add the multiplicand (shifted by counter) if the multiplier bit[counter] is 1, then counter+1. After WIDTH iterations go to DONE.
- DONE (one cycle):
  - Register {hi_o,result_o}=product, plus zero_o; cout_o=overflow_o=0.
  - valid_o=1, ready_o=1; next state IDLE.
  - A start_i seen in DONE is accepted (back-to-back issue).
  - MULU latency: valid after WIDTH+1 edges from the accept edge.
- start_i while ready_o=0: ignored, no queueing; operands are not re-sampled.
- Arithmetic:
  - ADD: {cout,sum}=A+B.
  - SUB: {cout,diff}=A+~B+1, so cout=1 means no borrow.
  - overflow: ADD when A[msb]==B[msb] and sum[msb]!=A[msb]; SUB when A[msb]!=B[msb] and diff[msb]!=A[msb].
  - SLT: result=(diff[msb] XOR overflow_sub) zero-extended; its flags cout_o and overflow_o are 0.
  - AND/OR/NOR: bitwise; cout_o=overflow_o=0.
  - hi_o=0 for all non-MULU ops.
- Illegal opcode: accepted, result_o=0, hi_o=0, zero_o=1, illegal_o=1, single valid pulse. illegal_o clears on the next valid.
- Outputs hold their value between valid pulses; consumers sample only when valid_o=1.
- ctrl_i and src*_i are don't-care except at the accepting edge.

Test Plan:
- WIDTH=8. Reset held, then released; ADD 0x7F+0x01 -> after 1 edge: valid_o=1 for 1 cycle, result_o=0x80, overflow_o=1, cout_o=0, zero_o=0.
- WIDTH=8. SUB 0x05-0x05 -> result_o=0x00, zero_o=1, cout_o=1, overflow_o=0. SLT 0x80 vs 0x01 -> result_o=0x01. SLT 0x01 vs 0x80 -> 0x00.
- WIDTH=8. MULU 0xFF*0xFF -> ready_o low for 8 cycles; valid_o on the 9th edge after accept; hi_o=0xFE, result_o=0x01, zero_o=0. A start_i pulsed mid-operation is ignored.
- WIDTH=8. MULU 0x00*0xAB -> zero_o=1. Issue AND 0xF0&0x3C in the DONE cycle -> next cycle valid_o=1, result_o=0x30, hi_o=0.
- WIDTH=32. Assert rst_i=0 at iteration 10 of a MULU -> all outputs 0 immediately, ready_o=1; no valid pulse after release; next ADD 1+2 gives result_o=3.
- ctrl_i=0101 -> valid_o pulse, illegal_o=1, result_o=0. Following legal OR 0x0F|0xF0 -> illegal_o=0, result_o=0xFF (WIDTH=8).

Source files
------------

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the control unit and the multicycle ALU.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] hi_o;
  logic             zero_o;
  logic             cout_o;
  logic             overflow_o;
  logic             illegal_o;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i,
    input  ready_o, valid_o, result_o, hi_o, zero_o, cout_o, overflow_o, illegal_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i,
    output ready_o, valid_o, result_o, hi_o, zero_o, cout_o, overflow_o, illegal_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// WIDTH-bit registered ALU: single-cycle logic/arith ops plus an iterative
// unsigned shift-add multiply behind a start/ready/valid handshake.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_multicycle_if.slave  bus
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;
  logic               valid_q, valid_d;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic               ovf_add;
  logic               ovf_sub;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cout;
  logic               alu_ovf;
  logic               alu_ill;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last_iter;

  assign sum_w   = {1'b0, bus.src1_i} + {1'b0, bus.src2_i};
  assign diff_w  = {1'b0, bus.src1_i} + {1'b0, ~bus.src2_i} + (WIDTH + 1)'(1);
  assign ovf_add = (bus.src1_i[MSB] == bus.src2_i[MSB]) && (sum_w[MSB]  != bus.src1_i[MSB]);
  assign ovf_sub = (bus.src1_i[MSB] != bus.src2_i[MSB]) && (diff_w[MSB] != bus.src1_i[MSB]);

  // Multiplicand is pre-shifted and multiplier consumed LSB-first, which is
  // equivalent to adding (mcand << cnt) when mplier[cnt] is set.
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Single-cycle ALU result and flags for the op presented on the bus
  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    unique case (bus.ctrl_i)
      OP_AND: alu_res = bus.src1_i & bus.src2_i;
      OP_OR:  alu_res = bus.src1_i | bus.src2_i;
      OP_NOR: alu_res = ~(bus.src1_i | bus.src2_i);
      OP_ADD: begin
        alu_res  = sum_w[MSB:0];
        alu_cout = sum_w[WIDTH];
        alu_ovf  = ovf_add;
      end
      OP_SUB: begin
        alu_res  = diff_w[MSB:0];
        alu_cout = diff_w[WIDTH];
        alu_ovf  = ovf_sub;
      end
      OP_SLT:  alu_res = {{(WIDTH - 1){1'b0}}, diff_w[MSB] ^ ovf_sub};
      OP_MULU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state and datapath updates; DONE accepts a new issue like IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    valid_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start_i) begin
          if (bus.ctrl_i == OP_MULU) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.src1_i};
            mplier_d = bus.src2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            hi_d     = '0;
            zero_d   = (alu_res == '0);
            cout_d   = alu_cout;
            ovf_d    = alu_ovf;
            ill_d    = alu_ill;
            valid_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Product lands on the outputs at the MUL->DONE edge so the DONE
        // cycle carries valid while staying free to accept a new issue.
        if (last_iter) begin
          state_d            = S_DONE;
          {hi_d, result_d}   = acc_sum;
          zero_d             = (acc_sum == '0);
          cout_d             = 1'b0;
          ovf_d              = 1'b0;
          ill_d              = 1'b0;
          valid_d            = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, result and flag registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ready_o    = (state_q != S_MUL);
  assign bus.valid_o    = valid_q;
  assign bus.result_o   = result_q;
  assign bus.hi_o       = hi_q;
  assign bus.zero_o     = zero_q;
  assign bus.cout_o     = cout_q;
  assign bus.overflow_o = ovf_q;
  assign bus.illegal_o  = ill_q;

endmodule
